layer_compositor: RTL

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/layer_compositor_pkg.sv | 31 +++
 rtl/layer_prio_mux.sv | 25 ++
 rtl/layer_compositor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/layer_compositor_pkg.sv
// Shared encodings for the layer compositor: game state codes, screen
// classes and the fade FSM states.
package layer_compositor_pkg;

  localparam logic [3:0] ST_GAMESTART = 4'd0;
  localparam logic [3:0] ST_EASY      = 4'd1;
  localparam logic [3:0] ST_NORMAL    = 4'd2;
  localparam logic [3:0] ST_HARD      = 4'd3;
  localparam logic [3:0] ST_INFERNO   = 4'd4;
  localparam logic [3:0] ST_FAILURE   = 4'd5;

  typedef enum logic [1:0] {
    CLS_START = 2'd0,
    CLS_PLAY  = 2'd1,
    CLS_FAIL  = 2'd2
  } scr_class_t;

  typedef enum logic [1:0] {
    FSM_IDLE     = 2'd0,
    FSM_FADE_OUT = 2'd1,
    FSM_FADE_IN  = 2'd2
  } fade_state_t;

  // Every code other than the two full-screen states counts as play.
  function automatic scr_class_t class_of(input logic [3:0] st);
    if (st == ST_GAMESTART)    return CLS_START;
    else if (st == ST_FAILURE) return CLS_FAIL;
    else                       return CLS_PLAY;
  endfunction

endpackage

// File: rtl/layer_prio_mux.sv
// Priority select of sprite layers: lowest-index opaque layer wins,
// background shows through when every layer is transparent.
module layer_prio_mux #(
  parameter int unsigned             N_LAYERS   = 4,
  parameter int unsigned             PIX_W      = 12,
  parameter logic [PIX_W-1:0]        TRANSP_KEY = '0
) (
  input  logic [N_LAYERS*PIX_W-1:0] layers,
  input  logic [PIX_W-1:0]          background,
  output logic [PIX_W-1:0]          sel_pix,
  output logic                      any_opaque
);

  always_comb begin
    sel_pix    = background;
    any_opaque = 1'b0;
    for (int unsigned i = 0; i < N_LAYERS; i++) begin
      if (!any_opaque && (layers[i*PIX_W +: PIX_W] != TRANSP_KEY)) begin
        sel_pix    = layers[i*PIX_W +: PIX_W];
        any_opaque = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// Two-stage sprite compositor with frame-synchronous fade between screen
// classes (START / PLAY / FAIL).
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int unsigned      N_LAYERS   = 4,
  parameter int unsigned      PIX_W      = 12,
  parameter logic [PIX_W-1:0] TRANSP_KEY = '0,
  parameter int unsigned      FADE_LOG2  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                state,
  input  logic                      pix_valid,
  input  logic                      frame_start,
  input  logic [PIX_W-1:0]          background,
  input  logic [N_LAYERS*PIX_W-1:0] layers,
  input  logic [PIX_W-1:0]          gamestart,
  input  logic [PIX_W-1:0]          failure,
  output logic [PIX_W-1:0]          pixel,
  output logic                      pixel_valid,
  output logic                      hit,
  output logic                      fade_busy
);

  localparam int unsigned     LVL_W   = FADE_LOG2 + 1;
  localparam int unsigned     PROD_W  = 4 + LVL_W;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(1) << FADE_LOG2;

  fade_state_t      fsm, fsm_nx;
  logic [LVL_W-1:0] level, level_nx;
  scr_class_t       disp_class, disp_nx;
  scr_class_t       tgt_class, tgt_nx;
  scr_class_t       live_class;

  logic [PIX_W-1:0] mux_pix;
  logic             mux_opaque;
  logic [PIX_W-1:0] s1_pix;
  logic             s1_hit;
  logic             s1_valid;
  logic [PIX_W-1:0] faded;

  assign live_class = class_of(state);
  assign fade_busy  = (fsm != FSM_IDLE);

  layer_prio_mux #(
    .N_LAYERS  (N_LAYERS),
    .PIX_W     (PIX_W),
    .TRANSP_KEY(TRANSP_KEY)
  ) u_prio (
    .layers    (layers),
    .background(background),
    .sel_pix   (mux_pix),
    .any_opaque(mux_opaque)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= FSM_IDLE;
      level      <= LVL_MAX;
      disp_class <= CLS_START;
      tgt_class  <= CLS_START;
    end else begin
      fsm        <= fsm_nx;
      level      <= level_nx;
      disp_class <= disp_nx;
      tgt_class  <= tgt_nx;
    end
  end

  // level only moves on frame_start, and the swap happens at the dark point.
  always_comb begin
    fsm_nx   = fsm;
    level_nx = level;
    disp_nx  = disp_class;
    tgt_nx   = tgt_class;
    unique case (fsm)
      FSM_IDLE: begin
        if (live_class != disp_class) begin
          tgt_nx = live_class;
          fsm_nx = FSM_FADE_OUT;
        end
      end
      FSM_FADE_OUT: begin
        tgt_nx = live_class;
        if (frame_start) begin
          if (level == '0) begin
            disp_nx = tgt_class;
            fsm_nx  = FSM_FADE_IN;
          end else begin
            level_nx = level - 1'b1;
          end
        end
      end
      FSM_FADE_IN: begin
        if (frame_start) begin
          if (level == LVL_MAX) fsm_nx = FSM_IDLE;
          else                  level_nx = level + 1'b1;
        end
      end
      default: fsm_nx = FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_hit   <= 1'b0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        unique case (disp_class)
          CLS_START: s1_pix <= gamestart;
          CLS_FAIL:  s1_pix <= failure;
          default:   s1_pix <= mux_pix;
        endcase
        s1_hit <= (disp_class == CLS_PLAY) && mux_opaque;
      end
    end
  end

  always_comb begin
    faded = '0;
    for (int unsigned ch = 0; ch < PIX_W / 4; ch++) begin
      faded[ch*4 +: 4] = 4'((PROD_W'(s1_pix[ch*4 +: 4]) * PROD_W'(level)) >> FADE_LOG2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      pixel       <= '0;
      hit         <= 1'b0;
    end else begin
      pixel_valid <= s1_valid;
      if (s1_valid) begin
        pixel <= faded;
        hit   <= s1_hit;
      end
    end
  end

endmodule
